// File: rtl/ysyx_22050612_lsu_pkg.sv
// Shared types and helpers for the load/store unit.
//   size_t  : access size encoding carried on req_size (B/H/W/D)
//   state_t : LSU sequencing states
//   is_split: true when an access starting at byte offset `off` runs past
//             the end of its 8-byte bus word
package ysyx_22050612_lsu_pkg;

  localparam int unsigned BUS_BYTES = 8;

  typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W, SZ_D} size_t;

  typedef enum logic [1:0] {IDLE, BEAT0, BEAT1, RESP} state_t;

  function automatic logic is_split(input logic [2:0] off, input size_t size);
    logic [3:0] end_byte;
    end_byte = {1'b0, off} + (4'd1 << size);
    return end_byte > 4'(BUS_BYTES);
  endfunction

endpackage

// File: rtl/ysyx_22050612_lsu_if.sv
// Bundle of all LSU handshake/bus signals.
//   req_*  : EXU -> LSU memory op (valid/ready)
//   resp_* : LSU -> writeback completion (valid/ready)
//   mem_*  : LSU -> 8-byte-aligned data bus (valid/ready, rdata same cycle)
// Modports:
//   master : the LSU's view (drives req_ready, resp_*, mem_* requests)
//   slave  : the environment's view (EXU, writeback and memory together)
interface ysyx_22050612_lsu_if #(
  parameter int XLEN = 64,
  parameter int RD_W = 5
);
  logic            req_valid;
  logic            req_ready;
  logic            req_wen;
  logic [XLEN-1:0] req_addr;
  logic [XLEN-1:0] req_wdata;
  logic [1:0]      req_size;
  logic            req_signed;
  logic [RD_W-1:0] req_rd;

  logic            resp_valid;
  logic            resp_ready;
  logic [XLEN-1:0] resp_rdata;
  logic [RD_W-1:0] resp_rd;
  logic            resp_wen;

  logic            mem_valid;
  logic            mem_ready;
  logic [XLEN-1:0] mem_addr;
  logic            mem_wen;
  logic [XLEN-1:0] mem_wdata;
  logic [7:0]      mem_wmask;
  logic [XLEN-1:0] mem_rdata;

  modport master (
    input  req_valid, req_wen, req_addr, req_wdata, req_size, req_signed, req_rd,
    output req_ready,
    output resp_valid, resp_rdata, resp_rd, resp_wen,
    input  resp_ready,
    output mem_valid, mem_addr, mem_wen, mem_wdata, mem_wmask,
    input  mem_ready, mem_rdata
  );

  modport slave (
    output req_valid, req_wen, req_addr, req_wdata, req_size, req_signed, req_rd,
    input  req_ready,
    input  resp_valid, resp_rdata, resp_rd, resp_wen,
    output resp_ready,
    input  mem_valid, mem_addr, mem_wen, mem_wdata, mem_wmask,
    output mem_ready, mem_rdata
  );

endinterface

// File: rtl/ysyx_22050612_lsu_align.sv
// Combinational lane alignment for the LSU.
//   size, off, sgn : access size, byte offset within the 8-byte word, sign flag
//   wdata          : right-justified store data
//   st_data        : store data shifted into a 16-byte (two-beat) window
//   st_mask        : byte-enable mask over the same 16-byte window
//   rdata0/rdata1  : bus words of beat 0 and beat 1 (rdata1 = 0 if unsplit)
//   ld_data        : load result, shifted down, truncated and extended
module ysyx_22050612_lsu_align
  import ysyx_22050612_lsu_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  size_t                  size,
  input  logic [2:0]             off,
  input  logic                   sgn,
  input  logic [XLEN-1:0]        wdata,
  output logic [2*XLEN-1:0]      st_data,
  output logic [2*BUS_BYTES-1:0] st_mask,
  input  logic [XLEN-1:0]        rdata0,
  input  logic [XLEN-1:0]        rdata1,
  output logic [XLEN-1:0]        ld_data
);

  logic [5:0]           shamt;
  logic [BUS_BYTES-1:0] byte_mask;
  logic [XLEN-1:0]      ld_raw;

  always_comb begin
    shamt = {off, 3'b000};

    case (size)
      SZ_B:    byte_mask = 8'h01;
      SZ_H:    byte_mask = 8'h03;
      SZ_W:    byte_mask = 8'h0F;
      default: byte_mask = 8'hFF;
    endcase

    st_data = {{XLEN{1'b0}}, wdata} << shamt;
    st_mask = {{BUS_BYTES{1'b0}}, byte_mask} << off;

    // Both beats are concatenated so one shift handles split and unsplit loads.
    ld_raw = XLEN'({rdata1, rdata0} >> shamt);

    case (size)
      SZ_B:    ld_data = {{(XLEN-8){sgn & ld_raw[7]}},   ld_raw[7:0]};
      SZ_H:    ld_data = {{(XLEN-16){sgn & ld_raw[15]}}, ld_raw[15:0]};
      SZ_W:    ld_data = {{(XLEN-32){sgn & ld_raw[31]}}, ld_raw[31:0]};
      default: ld_data = ld_raw;
    endcase
  end

endmodule

// File: rtl/ysyx_22050612_lsu.sv
// Multi-cycle load/store unit downstream of the EXU.
//   clk, rst_n : clock (rising edge), asynchronous active-low reset
//   bus        : req_* from EXU, resp_* to writeback, mem_* to the data bus
// One op in flight: IDLE -> BEAT0 -> [BEAT1] -> RESP -> IDLE. Accesses that
// cross an 8-byte boundary take a second bus beat. All outputs are registered.
module ysyx_22050612_lsu
  import ysyx_22050612_lsu_pkg::*;
#(
  parameter int XLEN = 64,
  parameter int RD_W = 5
) (
  input  logic                       clk,
  input  logic                       rst_n,
  ysyx_22050612_lsu_if.master        bus
);

  state_t               state_q, state_d;
  logic                 wen_q, wen_d;
  logic [2:0]           off_q, off_d;
  size_t                size_q, size_d;
  logic                 sgn_q, sgn_d;
  logic [RD_W-1:0]      rd_q, rd_d;
  logic                 split_q, split_d;
  logic [XLEN-1:0]      wdata_hi_q, wdata_hi_d;
  logic [BUS_BYTES-1:0] wmask_hi_q, wmask_hi_d;
  logic [XLEN-1:0]      rdata0_q, rdata0_d;

  logic                 req_ready_q, req_ready_d;
  logic                 resp_valid_q, resp_valid_d;
  logic [XLEN-1:0]      resp_rdata_q, resp_rdata_d;
  logic [RD_W-1:0]      resp_rd_q, resp_rd_d;
  logic                 resp_wen_q, resp_wen_d;
  logic                 mem_valid_q, mem_valid_d;
  logic [XLEN-1:0]      mem_addr_q, mem_addr_d;
  logic                 mem_wen_q, mem_wen_d;
  logic [XLEN-1:0]      mem_wdata_q, mem_wdata_d;
  logic [BUS_BYTES-1:0] mem_wmask_q, mem_wmask_d;

  size_t                  al_size;
  logic [2:0]             al_off;
  logic                   al_sgn;
  logic [XLEN-1:0]        al_rdata0;
  logic [XLEN-1:0]        al_rdata1;
  logic [2*XLEN-1:0]      st_data;
  logic [2*BUS_BYTES-1:0] st_mask;
  logic [XLEN-1:0]        ld_data;
  logic                   last_beat;

  // Shared aligner: fed from the live request in IDLE (store lanes are
  // computed at accept time), from the captured op afterwards (load merge).
  ysyx_22050612_lsu_align #(
    .XLEN (XLEN)
  ) u_align (
    .size    (al_size),
    .off     (al_off),
    .sgn     (al_sgn),
    .wdata   (bus.req_wdata),
    .st_data (st_data),
    .st_mask (st_mask),
    .rdata0  (al_rdata0),
    .rdata1  (al_rdata1),
    .ld_data (ld_data)
  );

  always_comb begin
    state_d      = state_q;
    wen_d        = wen_q;
    off_d        = off_q;
    size_d       = size_q;
    sgn_d        = sgn_q;
    rd_d         = rd_q;
    split_d      = split_q;
    wdata_hi_d   = wdata_hi_q;
    wmask_hi_d   = wmask_hi_q;
    rdata0_d     = rdata0_q;
    req_ready_d  = req_ready_q;
    resp_valid_d = resp_valid_q;
    resp_rdata_d = resp_rdata_q;
    resp_rd_d    = resp_rd_q;
    resp_wen_d   = resp_wen_q;
    mem_valid_d  = mem_valid_q;
    mem_addr_d   = mem_addr_q;
    mem_wen_d    = mem_wen_q;
    mem_wdata_d  = mem_wdata_q;
    mem_wmask_d  = mem_wmask_q;
    last_beat    = 1'b0;

    if (state_q == IDLE) begin
      al_size = size_t'(bus.req_size);
      al_off  = bus.req_addr[2:0];
      al_sgn  = bus.req_signed;
    end else begin
      al_size = size_q;
      al_off  = off_q;
      al_sgn  = sgn_q;
    end
    al_rdata0 = (state_q == BEAT1) ? rdata0_q : bus.mem_rdata;
    al_rdata1 = (state_q == BEAT1) ? bus.mem_rdata : '0;

    case (state_q)
      IDLE: begin
        if (bus.req_valid && req_ready_q) begin
          state_d     = BEAT0;
          wen_d       = bus.req_wen;
          off_d       = bus.req_addr[2:0];
          size_d      = size_t'(bus.req_size);
          sgn_d       = bus.req_signed;
          rd_d        = bus.req_rd;
          split_d     = is_split(bus.req_addr[2:0], size_t'(bus.req_size));
          req_ready_d = 1'b0;
          mem_valid_d = 1'b1;
          mem_addr_d  = {bus.req_addr[XLEN-1:3], 3'b000};
          mem_wen_d   = bus.req_wen;
          if (bus.req_wen) begin
            mem_wdata_d = st_data[XLEN-1:0];
            mem_wmask_d = st_mask[BUS_BYTES-1:0];
            wdata_hi_d  = st_data[2*XLEN-1:XLEN];
            wmask_hi_d  = st_mask[2*BUS_BYTES-1:BUS_BYTES];
          end else begin
            mem_wdata_d = '0;
            mem_wmask_d = '0;
            wdata_hi_d  = '0;
            wmask_hi_d  = '0;
          end
        end
      end
      BEAT0: begin
        if (bus.mem_ready) begin
          if (split_q) begin
            state_d     = BEAT1;
            rdata0_d    = bus.mem_rdata;
            mem_addr_d  = mem_addr_q + XLEN'(BUS_BYTES);
            mem_wdata_d = wdata_hi_q;
            mem_wmask_d = wmask_hi_q;
          end else begin
            last_beat = 1'b1;
          end
        end
      end
      BEAT1: begin
        if (bus.mem_ready) last_beat = 1'b1;
      end
      RESP: begin
        if (bus.resp_ready) begin
          state_d      = IDLE;
          resp_valid_d = 1'b0;
          req_ready_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (last_beat) begin
      state_d      = RESP;
      mem_valid_d  = 1'b0;
      resp_valid_d = 1'b1;
      resp_rdata_d = wen_q ? '0 : ld_data;
      resp_rd_d    = rd_q;
      resp_wen_d   = !wen_q && (rd_q != '0);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      wen_q        <= 1'b0;
      off_q        <= '0;
      size_q       <= SZ_B;
      sgn_q        <= 1'b0;
      rd_q         <= '0;
      split_q      <= 1'b0;
      wdata_hi_q   <= '0;
      wmask_hi_q   <= '0;
      rdata0_q     <= '0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_rd_q    <= '0;
      resp_wen_q   <= 1'b0;
      mem_valid_q  <= 1'b0;
      mem_addr_q   <= '0;
      mem_wen_q    <= 1'b0;
      mem_wdata_q  <= '0;
      mem_wmask_q  <= '0;
    end else begin
      state_q      <= state_d;
      wen_q        <= wen_d;
      off_q        <= off_d;
      size_q       <= size_d;
      sgn_q        <= sgn_d;
      rd_q         <= rd_d;
      split_q      <= split_d;
      wdata_hi_q   <= wdata_hi_d;
      wmask_hi_q   <= wmask_hi_d;
      rdata0_q     <= rdata0_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_rd_q    <= resp_rd_d;
      resp_wen_q   <= resp_wen_d;
      mem_valid_q  <= mem_valid_d;
      mem_addr_q   <= mem_addr_d;
      mem_wen_q    <= mem_wen_d;
      mem_wdata_q  <= mem_wdata_d;
      mem_wmask_q  <= mem_wmask_d;
    end
  end

  assign bus.req_ready  = req_ready_q;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_rdata = resp_rdata_q;
  assign bus.resp_rd    = resp_rd_q;
  assign bus.resp_wen   = resp_wen_q;
  assign bus.mem_valid  = mem_valid_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_wen    = mem_wen_q;
  assign bus.mem_wdata  = mem_wdata_q;
  assign bus.mem_wmask  = mem_wmask_q;

endmodule

// File: tb/tb_ysyx_22050612_lsu.sv
// Self-checking bench for ysyx_22050612_lsu. The bench plays EXU, writeback
// and a byte-addressed memory; expectations come from a byte-level model.
module tb_ysyx_22050612_lsu;

  logic clk;
  logic rst_n;

  ysyx_22050612_lsu_if #(.XLEN(64), .RD_W(5)) bus ();

  ysyx_22050612_lsu #(.XLEN(64), .RD_W(5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_pass  = 0;
  int unsigned n_total = 0;

  logic [7:0]  mem [longint unsigned];
  logic [63:0] obs_addr  [2];
  logic [7:0]  obs_mask  [2];
  logic [63:0] obs_wdata [2];

  typedef struct {
    bit          wen;
    logic [63:0] addr;
    logic [63:0] wdata;
    int unsigned sz;
    bit          sgn;
    logic [4:0]  rd;
    logic [63:0] w0;
    logic [63:0] w1;
    logic [63:0] exp_rdata;
    bit          exp_wen;
    int unsigned exp_beats;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%h required 0x%h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] rd_byte(input logic [63:0] a);
    if (mem.exists(a)) return mem[a];
    return (a[7:0] ^ a[15:8]) ^ 8'h5A;
  endfunction

  function automatic logic [63:0] model_load(input logic [63:0] a, input int unsigned sz, input bit sgn);
    int unsigned n;
    logic [63:0] v;
    n = 1 << sz;
    v = '0;
    for (int unsigned i = 0; i < n; i++) v[8*i +: 8] = rd_byte(a + 64'(i));
    if (sgn && n < 8 && v[8*n-1]) v = v | (~64'd0 << (8*n));
    return v;
  endfunction

  // Lane j of beat b holds store byte k = 8b + j - off.
  task automatic model_beat(input logic [63:0] wdata, input int unsigned off, input int unsigned n,
                            input int unsigned beat, output logic [7:0] m, output logic [63:0] d);
    m = '0;
    d = '0;
    for (int unsigned j = 0; j < 8; j++) begin
      int k;
      k = int'(8*beat + j) - int'(off);
      if (k >= 0 && k < 8) d[8*j +: 8] = wdata[8*k +: 8];
      if (k >= 0 && k < int'(n)) m[j] = 1'b1;
    end
  endtask

  task automatic preload(input logic [63:0] addr, input logic [63:0] w0, input logic [63:0] w1);
    logic [63:0] base;
    base = {addr[63:3], 3'b000};
    for (int unsigned i = 0; i < 8; i++) begin
      mem[base + 64'(i)]     = w0[8*i +: 8];
      mem[base + 64'(8 + i)] = w1[8*i +: 8];
    end
  endtask

  task automatic do_op(input bit wen, input logic [63:0] addr, input logic [63:0] wdata,
                       input int unsigned sz, input bit sgn, input logic [4:0] rd,
                       input int unsigned mstall, input int unsigned rstall,
                       output logic [63:0] got_rdata, output bit got_wen, output int unsigned beats);
    int unsigned off, n, nb, idle, cyc;
    logic [63:0] base, exp_rdata, d, a0, d0, r0, rword;
    logic [7:0]  m, m0;
    logic        exp_wen;
    off = int'(addr[2:0]);
    n = 1 << sz;
    nb = (off + n > 8) ? 2 : 1;
    base = {addr[63:3], 3'b000};
    exp_rdata = wen ? 64'd0 : model_load(addr, sz, sgn);
    exp_wen = !wen && (rd != 5'd0);

    check("req_ready_idle", bus.req_ready, 1);
    bus.req_valid  = 1'b1;
    bus.req_wen    = wen;
    bus.req_addr   = addr;
    bus.req_wdata  = wdata;
    bus.req_size   = 2'(sz);
    bus.req_signed = sgn;
    bus.req_rd     = rd;
    tick();
    bus.req_valid = 1'b0;
    bus.req_addr  = {$urandom, $urandom};
    bus.req_wdata = {$urandom, $urandom};
    bus.req_size  = 2'($urandom_range(3, 0));
    bus.req_rd    = 5'($urandom);

    beats = 0;
    idle = 0;
    cyc = 0;
    while (!bus.resp_valid && cyc < 64 && beats < 3) begin
      cyc++;
      if (bus.mem_valid) begin
        model_beat(wdata, off, n, beats, m, d);
        check("mem_addr", bus.mem_addr, base + 64'(8*beats));
        check("mem_wen", bus.mem_wen, wen);
        check("mem_wmask", bus.mem_wmask, wen ? m : 8'h00);
        if (wen) check("mem_wdata", bus.mem_wdata, d);
        check("req_ready_busy", bus.req_ready, 0);
        if (beats < 2) begin
          obs_addr[beats]  = bus.mem_addr;
          obs_mask[beats]  = bus.mem_wmask;
          obs_wdata[beats] = bus.mem_wdata;
        end
        a0 = bus.mem_addr;
        m0 = bus.mem_wmask;
        d0 = bus.mem_wdata;
        for (int unsigned s = 0; s < mstall; s++) begin
          tick();
          check("mem_hold", {bus.mem_valid, bus.req_ready, bus.resp_valid, bus.mem_addr == a0,
                             bus.mem_wmask == m0, bus.mem_wdata == d0, bus.mem_wen == wen}, 7'b1001111);
        end
        for (int unsigned j = 0; j < 8; j++) rword[8*j +: 8] = rd_byte(bus.mem_addr + 64'(j));
        bus.mem_rdata = rword;
        bus.mem_ready = 1'b1;
        tick();
        bus.mem_ready = 1'b0;
        bus.mem_rdata = {$urandom, $urandom};
        beats++;
      end else begin
        idle++;
        tick();
      end
    end
    check("bus_idle_cycles", idle, 0);
    check("beat_count", beats, nb);
    check("resp_valid", bus.resp_valid, 1);
    check("resp_rdata", bus.resp_rdata, exp_rdata);
    check("resp_rd", bus.resp_rd, rd);
    check("resp_wen", bus.resp_wen, exp_wen);
    check("resp_bus_quiet", {bus.mem_valid, bus.req_ready}, 2'b00);
    r0 = bus.resp_rdata;
    for (int unsigned s = 0; s < rstall; s++) begin
      tick();
      check("resp_hold", {bus.resp_valid, bus.req_ready, bus.mem_valid, bus.resp_rdata == r0,
                          bus.resp_rd == rd, bus.resp_wen == exp_wen}, 6'b100111);
    end
    got_rdata = bus.resp_rdata;
    got_wen = bus.resp_wen;
    bus.resp_ready = 1'b1;
    tick();
    bus.resp_ready = 1'b0;
    check("resp_done", {bus.resp_valid, bus.req_ready}, 2'b01);
    if (wen) for (int unsigned i = 0; i < n; i++) mem[addr + 64'(i)] = wdata[8*i +: 8];
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] r;
    bit w;
    int unsigned b;

    vecs[0] = '{0, 64'h8000_0003, 64'h0, 0, 1, 5'd5, 64'h1122_3344_8566_7788, 64'h0, 64'hFFFF_FFFF_FFFF_FF85, 1, 1};
    vecs[1] = '{1, 64'h8000_0007, 64'hABCD, 1, 0, 5'd3, 64'h0, 64'h0, 64'h0, 0, 2};
    vecs[2] = '{0, 64'h8000_0004, 64'h0, 3, 0, 5'd10, 64'hDDCC_BBAA_1234_5678, 64'h9ABC_DEF0_4433_2211, 64'h4433_2211_DDCC_BBAA, 1, 2};
    vecs[3] = '{0, 64'h8000_0004, 64'h0, 2, 0, 5'd0, 64'hF000_0001_0000_0000, 64'h0, 64'h0000_0000_F000_0001, 0, 1};
    vecs[4] = '{0, 64'h8000_0006, 64'h0, 1, 1, 5'd1, 64'h8001_0000_0000_0000, 64'h0, 64'hFFFF_FFFF_FFFF_8001, 1, 1};
    vecs[5] = '{0, 64'h8000_0007, 64'h0, 1, 0, 5'd2, 64'h3400_0000_0000_0000, 64'h12, 64'h1234, 1, 2};
    vecs[6] = '{0, 64'h1000_0006, 64'h0, 2, 1, 5'd31, 64'hBBAA_0000_0000_0000, 64'hDDCC, 64'hFFFF_FFFF_DDCC_BBAA, 1, 2};
    vecs[7] = '{0, 64'h1000_0000, 64'h0, 0, 0, 5'd4, 64'hF7, 64'h0, 64'hF7, 1, 1};
    vecs[8] = '{1, 64'hFFFF_FFFF_FFFF_FFFC, 64'h0123_4567_89AB_CDEF, 3, 0, 5'd7, 64'h0, 64'h0, 64'h0, 0, 2};
    vecs[9] = '{0, 64'h8000_0000, 64'h0, 2, 1, 5'd9, 64'h7FFF_FFFF, 64'h0, 64'h7FFF_FFFF, 1, 1};

    rst_n = 1'b0;
    bus.req_valid = 1'b0; bus.req_wen = 1'b0; bus.req_addr = '0; bus.req_wdata = '0;
    bus.req_size = 2'd0; bus.req_signed = 1'b0; bus.req_rd = '0;
    bus.resp_ready = 1'b0; bus.mem_ready = 1'b0; bus.mem_rdata = '0;
    repeat (3) tick();

    check("rst_req_ready", bus.req_ready, 1);
    check("rst_valids", {bus.resp_valid, bus.mem_valid}, 2'b00);
    check("rst_resp_rdata", bus.resp_rdata, 0);
    check("rst_resp_rd_wen", {bus.resp_rd, bus.resp_wen}, 0);
    check("rst_mem_addr", bus.mem_addr, 0);
    check("rst_mem_wdata", bus.mem_wdata, 0);
    check("rst_mem_wmask", bus.mem_wmask, 0);
    rst_n = 1'b1;
    tick();

    // Reset while a beat is outstanding: outputs drop with no clock edge.
    bus.req_valid = 1'b1; bus.req_wen = 1'b0; bus.req_addr = 64'h8000_0010;
    bus.req_size = 2'd3; bus.req_rd = 5'd6;
    tick();
    bus.req_valid = 1'b0;
    check("midop_mem_valid", bus.mem_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    check("midop_rst_valids", {bus.mem_valid, bus.resp_valid}, 2'b00);
    check("midop_rst_req_ready", bus.req_ready, 1);
    tick();
    rst_n = 1'b1;
    tick();

    foreach (vecs[i]) begin
      preload(vecs[i].addr, vecs[i].w0, vecs[i].w1);
      do_op(vecs[i].wen, vecs[i].addr, vecs[i].wdata, vecs[i].sz, vecs[i].sgn, vecs[i].rd, 0, 0, r, w, b);
      check("vec_rdata", r, vecs[i].exp_rdata);
      check("vec_resp_wen", w, vecs[i].exp_wen);
      check("vec_beats", b, vecs[i].exp_beats);
    end

    // Signed byte load: single read beat, no write lanes.
    preload(64'h8000_0003, 64'h1122_3344_8566_7788, 64'h0);
    do_op(0, 64'h8000_0003, 64'h0, 0, 1, 5'd8, 0, 0, r, w, b);
    check("lb_beat_addr", obs_addr[0], 64'h8000_0000);
    check("lb_beat_mask", obs_mask[0], 8'h00);

    // Halfword store straddling the word boundary.
    do_op(1, 64'h8000_0007, 64'hABCD, 1, 0, 5'd3, 0, 0, r, w, b);
    check("sh_b0_addr", obs_addr[0], 64'h8000_0000);
    check("sh_b0_mask", obs_mask[0], 8'h80);
    check("sh_b0_lane", obs_wdata[0][63:56], 8'hCD);
    check("sh_b1_addr", obs_addr[1], 64'h8000_0008);
    check("sh_b1_mask", obs_mask[1], 8'h01);
    check("sh_b1_lane", obs_wdata[1][7:0], 8'hAB);
    check("sh_resp_wen", w, 0);

    // Long stalls on both the bus and the writeback side.
    preload(64'h8000_0004, 64'hDDCC_BBAA_0000_0000, 64'h0000_0000_4433_2211);
    do_op(0, 64'h8000_0004, 64'h0, 3, 0, 5'd12, 5, 3, r, w, b);
    check("stall_rdata", r, 64'h4433_2211_DDCC_BBAA);
    do_op(1, 64'h8000_0005, 64'h1122_3344, 2, 0, 5'd1, 5, 3, r, w, b);
    check("stall_store_beats", b, 2);

    // Random traffic against the byte-level memory model.
    for (int unsigned t = 0; t < 300; t++) begin
      logic [63:0] a;
      if ($urandom_range(9, 0) == 0) a = 64'hFFFF_FFFF_FFFF_FFF0 + 64'($urandom_range(15, 0));
      else a = 64'h8000_0000 + 64'($urandom_range(63, 0));
      do_op(1'($urandom_range(1, 0)), a, {$urandom, $urandom}, $urandom_range(3, 0),
            1'($urandom_range(1, 0)), 5'($urandom), $urandom_range(2, 0), $urandom_range(2, 0), r, w, b);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
